// File: rtl/npu_ram_pkg.sv
// npu_ram_pkg: shared types and constants for the NPU RAM access logic.
// Holds the read-streamer FSM encoding and the RAM read latency.
package npu_ram_pkg;

    localparam int RAM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ISSUE  = 2'd1,
        RD_DRAIN  = 2'd2,
        RD_FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/sync_skid_fifo.sv
// sync_skid_fifo: single-clock FIFO with occupancy count output.
// Head entry is visible on rd_data_o whenever empty_o is low.
module sync_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_rd;
    logic             do_wr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_rd = rd_en_i && (count_q != '0);
    // A write into a full buffer is only legal when the head leaves this cycle.
    assign do_wr = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/dpram_rd_streamer.sv
// dpram_rd_streamer: bursts sequential reads out of dpram_2p and
// delivers the words as a valid/ready stream with full backpressure.
module dpram_rd_streamer
    import npu_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  rdreq,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OUT_W = $clog2(SKID_DEPTH + RAM_RD_LATENCY + 1);

    rd_state_e               state_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    issue_cnt_q;
    logic [LEN_WIDTH-1:0]    accept_cnt_q;
    logic [LEN_WIDTH-1:0]    accept_cnt_d;
    logic [RAM_RD_LATENCY-1:0] vld_q;

    logic [CNT_W-1:0]        skid_cnt;
    logic                    skid_empty;
    logic [OUT_W-1:0]        outstanding;
    logic                    credit;
    logic                    issue;
    logic                    pop;
    logic                    drain_done;

    // Every issued read already owns a skid slot, so the buffer never overflows.
    always_comb begin
        outstanding = OUT_W'(skid_cnt);
        for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            outstanding = outstanding + OUT_W'(vld_q[i]);
        end
    end

    assign credit       = (outstanding < OUT_W'(SKID_DEPTH));
    assign issue        = (state_q == RD_ISSUE) && credit;
    assign pop          = m_valid && m_ready;
    assign accept_cnt_d = accept_cnt_q + LEN_WIDTH'(pop);
    assign drain_done   = (vld_q == '0) &&
                          (skid_cnt == CNT_W'(pop)) &&
                          (accept_cnt_d == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            cur_addr_q   <= '0;
            len_q        <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            vld_q        <= '0;
        end else begin
            vld_q        <= {vld_q[RAM_RD_LATENCY-2:0], issue};
            accept_cnt_q <= accept_cnt_d;
            unique case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        issue_cnt_q  <= '0;
                        accept_cnt_q <= '0;
                        if (len != '0) begin
                            cur_addr_q <= base_addr;
                            len_q      <= len;
                            state_q    <= RD_ISSUE;
                        end else begin
                            state_q    <= RD_FINISH;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (issue) begin
                        cur_addr_q  <= cur_addr_q + ADDR_WIDTH'(1);
                        issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
                        if (issue_cnt_q + LEN_WIDTH'(1) == len_q) begin
                            state_q <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (drain_done) begin
                        state_q <= RD_FINISH;
                    end
                end
                RD_FINISH: state_q <= RD_IDLE;
                default:   state_q <= RD_IDLE;
            endcase
        end
    end

    sync_skid_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (vld_q[RAM_RD_LATENCY-1]),
        .wr_data_i (q),
        .rd_en_i   (m_ready),
        .rd_data_o (m_data),
        .empty_o   (skid_empty),
        .count_o   (skid_cnt)
    );

    assign rdreq   = issue;
    assign rdaddr  = cur_addr_q;
    assign busy    = (state_q != RD_IDLE);
    assign done    = (state_q == RD_FINISH);
    assign m_valid = !skid_empty;

endmodule

// File: tb/tb_dpram_rd_streamer.sv
// tb_dpram_rd_streamer: random-stimulus bench with a behavioural
// two-cycle-latency RAM and an address-indexed expected-data model.
module tb_dpram_rd_streamer;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LW = 7;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] q = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, rdreq, m_valid;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] m_data;

    dpram_rd_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .SKID_DEPTH (SD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rdreq     (rdreq),
        .rdaddr    (rdaddr),
        .q         (q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // RAM read port: request registered at one edge, q updated at the next.
    logic [DW-1:0] mem [64];
    logic          req1 = 1'b0;
    logic [AW-1:0] a1 = '0;
    always @(posedge clk) begin
        req1 <= rdreq;
        a1   <= rdaddr;
        if (req1) q <= mem[a1];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_edge, first_valid, first_hs, last_hs, done_cyc;
    int done_cnt, busy_nd, outst, max_outst, stall_err;
    bit timeout, prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] iss_q [$];
    logic [DW-1:0] got_q [$];

    task automatic clear_mon();
        iss_q.delete();
        got_q.delete();
        first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
        done_cnt = 0; busy_nd = 0; outst = 0; max_outst = 0;
        stall_err = 0; prev_stall = 0; timeout = 0;
    endtask

    task automatic sample();
        if (!rst_n) begin
            outst = 0;
            prev_stall = 0;
        end else begin
            if (rdreq) begin
                iss_q.push_back(rdaddr);
                outst++;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                outst--;
            end
            if (outst > max_outst) max_outst = outst;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && !done) busy_nd++;
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < 64; i++) mem[i] = rnd ? DW'($urandom()) : DW'(i + 100);
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                             input int rmode, input bit inject);
        int n;
        int hold_at;
        clear_mon();
        hold_at = int'($urandom_range(2, 8));
        base_addr = b;
        len = l;
        m_ready = (rmode == 0);
        start = 1'b1;
        start_edge = cyc + 1;
        step();
        start = 1'b0;
        base_addr = AW'($urandom());
        len = LW'($urandom());
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            if (rmode == 0) m_ready = 1'b1;
            else if (n >= hold_at && n < hold_at + 10) m_ready = 1'b0;
            else m_ready = 1'($urandom_range(0, 1));
            if (inject && n == 4) begin
                start = 1'b1;
                base_addr = 6'd40;
                len = 7'd5;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        if (done_cnt == 0) timeout = 1'b1;
        m_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_rdreq: got %b want 0", rdreq); end
        n_cmp++; if (rdaddr !== '0) begin n_bad++; $display("FAIL reset_rdaddr: got %0d want 0", rdaddr); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: busy %b m_valid %b want 0 0", busy, m_valid); end
    endtask

    task automatic test_basic();
        load_mem(1'b0);
        run_burst(6'd5, 7'd8, 0, 1'b0);
        n_cmp++; if (timeout) begin n_bad++; $display("FAIL basic_timeout: done never seen"); end
        n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL basic_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== DW'(105 + i)) begin
                n_bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got_q[i], 105 + i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= iss_q.size() || iss_q[i] !== AW'(5 + i)) begin
                n_bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, iss_q[i], 5 + i);
            end
        end
        n_cmp++; if (first_valid - start_edge != 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", first_valid - start_edge); end
        n_cmp++; if (last_hs - first_hs != 7) begin n_bad++; $display("FAIL basic_no_bubbles: got span %0d want 7", last_hs - first_hs); end
        n_cmp++; if (done_cyc != last_hs + 1) begin n_bad++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_hs + 1); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_nd != 11) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 11", busy_nd); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        run_burst(6'd60, 7'd8, 0, 1'b0);
        n_cmp++; if (iss_q.size() != 8) begin n_bad++; $display("FAIL wrap_issue_count: got %0d want 8", iss_q.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = 6'd60 + AW'(i);
            n_cmp++;
            if (i >= iss_q.size() || iss_q[i] !== ea) begin
                n_bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, iss_q[i], ea);
            end
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== mem[ea]) begin
                n_bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, got_q[i], mem[ea]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b;
        logic [LW-1:0] l;
        logic [AW-1:0] ea;
        load_mem(1'b1);
        for (int k = 0; k < 4; k++) begin
            b = AW'($urandom());
            l = (k == 0) ? 7'd8 : LW'($urandom_range(1, 24));
            run_burst(b, l, 1, 1'b0);
            n_cmp++; if (timeout) begin n_bad++; $display("FAIL bp_timeout[%0d]: done never seen", k); end
            n_cmp++; if (got_q.size() != int'(l)) begin n_bad++; $display("FAIL bp_count[%0d]: got %0d want %0d", k, got_q.size(), l); end
            n_cmp++; if (iss_q.size() != int'(l)) begin n_bad++; $display("FAIL bp_issues[%0d]: got %0d want %0d", k, iss_q.size(), l); end
            for (int i = 0; i < int'(l); i++) begin
                ea = b + AW'(i);
                n_cmp++;
                if (i >= got_q.size() || got_q[i] !== mem[ea]) begin
                    n_bad++; $display("FAIL bp_data[%0d][%0d]: got %0h want %0h", k, i, got_q[i], mem[ea]);
                end
            end
            n_cmp++; if (max_outst > SD) begin n_bad++; $display("FAIL bp_credit[%0d]: got %0d outstanding want <= %0d", k, max_outst, SD); end
            n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL bp_stable[%0d]: got %0d unstable cycles want 0", k, stall_err); end
            n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done[%0d]: got %0d want 1", k, done_cnt); end
        end
    endtask

    task automatic test_len_zero();
        run_burst(AW'($urandom()), 7'd0, 0, 1'b0);
        n_cmp++; if (iss_q.size() != 0) begin n_bad++; $display("FAIL zero_rdreq: got %0d reads want 0", iss_q.size()); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL zero_data: got %0d words want 0", got_q.size()); end
        n_cmp++; if (done_cyc != start_edge) begin n_bad++; $display("FAIL zero_done_timing: got %0d want %0d", done_cyc, start_edge); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        logic [AW-1:0] ea;
        run_burst(6'd10, 7'd8, 0, 1'b1);
        n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL ign_count: got %0d want 8", got_q.size()); end
        n_cmp++; if (iss_q.size() != 8) begin n_bad++; $display("FAIL ign_issues: got %0d want 8", iss_q.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = 6'd10 + AW'(i);
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== mem[ea]) begin
                n_bad++; $display("FAIL ign_data[%0d]: got %0h want %0h", i, got_q[i], mem[ea]);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        base_addr = 6'd20;
        len = 7'd8;
        m_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_cmp++; if (iss_q.size() != 2) begin n_bad++; $display("FAIL mid_inflight: got %0d want 2", iss_q.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: busy %b done %b want 0 0", busy, done); end
        n_cmp++; if (rdreq !== 1'b0 || rdaddr !== '0) begin n_bad++; $display("FAIL mid_rst_rd: rdreq %b rdaddr %0d want 0 0", rdreq, rdaddr); end
        n_cmp++; if (m_valid !== 1'b0 || m_data !== '0) begin n_bad++; $display("FAIL mid_rst_stream: m_valid %b m_data %0h want 0 0", m_valid, m_data); end
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_capture: got m_valid %b want 0", m_valid); end
        run_burst(6'd0, 7'd4, 0, 1'b0);
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL mid_after_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== mem[i]) begin
                n_bad++; $display("FAIL mid_after_data[%0d]: got %0h want %0h", i, got_q[i], mem[i]);
            end
        end
    endtask

    task automatic test_full_depth();
        logic [AW-1:0] b;
        logic [AW-1:0] ea;
        load_mem(1'b1);
        b = AW'($urandom());
        run_burst(b, 7'd64, 0, 1'b0);
        n_cmp++; if (timeout) begin n_bad++; $display("FAIL full_timeout: done never seen"); end
        n_cmp++; if (got_q.size() != 64) begin n_bad++; $display("FAIL full_count: got %0d want 64", got_q.size()); end
        for (int i = 0; i < 64; i++) begin
            ea = b + AW'(i);
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== mem[ea]) begin
                n_bad++; $display("FAIL full_data[%0d]: got %0h want %0h", i, got_q[i], mem[ea]);
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_nd != 3 + 64) begin n_bad++; $display("FAIL full_busy_cycles: got %0d want 67", busy_nd); end
        n_cmp++; if (last_hs - first_hs != 63) begin n_bad++; $display("FAIL full_no_bubbles: got span %0d want 63", last_hs - first_hs); end
    endtask

    initial begin
        clear_mon();
        load_mem(1'b0);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
